// File: rtl/ps2_keycode_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame/decoder states,
// scan-code prefixes and the HID codes produced by the key map.
package ps2_keycode_rx_pkg;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_state_t;
   typedef enum logic [1:0] {NORM, GOT_E0, GOT_F0, GOT_E0F0} dec_state_t;

   localparam logic [7:0] SC_PREFIX_E0 = 8'hE0;
   localparam logic [7:0] SC_BREAK_F0  = 8'hF0;

   // Set-2 make codes of the keys the game uses
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_SPACE = 8'h29;
   localparam logic [7:0] SC_ENTER = 8'h5A;
   localparam logic [7:0] SC_ESC   = 8'h76;

   localparam logic [7:0] HID_NONE  = 8'h00;
   localparam logic [7:0] HID_A     = 8'h04;
   localparam logic [7:0] HID_D     = 8'h07;
   localparam logic [7:0] HID_W     = 8'h1A;
   localparam logic [7:0] HID_S     = 8'h16;
   localparam logic [7:0] HID_SPACE = 8'h2C;
   localparam logic [7:0] HID_ENTER = 8'h28;
   localparam logic [7:0] HID_ESC   = 8'h29;

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// Keyboard-side pins plus decoded outputs of the PS/2 receiver.
// master drives the PS/2 lines, slave is the receiver.
interface ps2_keycode_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] keycode;
   logic [7:0] rx_byte;
   logic       rx_strobe;
   logic       ext;
   logic       frame_err;

   modport master (
      output ps2_clk, ps2_data,
      input  keycode, rx_byte, rx_strobe, ext, frame_err
   );

   modport slave (
      input  ps2_clk, ps2_data,
      output keycode, rx_byte, rx_strobe, ext, frame_err
   );
endinterface

// File: rtl/ps2_to_hid.sv
// Combinational set-2 scan code to USB-HID usage map; unknown codes give 0x00.
module ps2_to_hid
   import ps2_keycode_rx_pkg::*;
(
   input  logic [7:0] scan,
   output logic [7:0] hid
);
   always_comb begin
      hid = HID_NONE;
      case (scan)
         SC_A:     hid = HID_A;
         SC_D:     hid = HID_D;
         SC_W:     hid = HID_W;
         SC_S:     hid = HID_S;
         SC_SPACE: hid = HID_SPACE;
         SC_ENTER: hid = HID_ENTER;
         SC_ESC:   hid = HID_ESC;
         default:  hid = HID_NONE;
      endcase
   end
endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronize and deglitch the lines, deframe 11-bit frames,
// and track the currently held key as a HID keycode.
module ps2_keycode_rx
   import ps2_keycode_rx_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
)(
   input  logic           Clk,
   input  logic           Reset,
   ps2_keycode_rx_if.slave bus
);
   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);

   // bit 0: ps2_clk, bit 1: ps2_data; idle level of both lines is high
   logic [1:0] raw_in;
   logic [1:0] sync_in;
   assign raw_in = {bus.ps2_data, bus.ps2_clk};

   for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge Clk or posedge Reset) begin
         if (Reset) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
         end else begin
            meta_reg <= raw_in[gi];
            sync_reg <= meta_reg;
         end
      end
      assign sync_in[gi] = sync_reg;
   end

   logic clk_sync;
   logic data_sync;
   assign clk_sync  = sync_in[0];
   assign data_sync = sync_in[1];

   logic [FCW-1:0] filt_cnt_reg;
   logic           filt_reg;
   logic           flip;
   logic           fall;

   // The filtered level flips on the FILTER_LEN-th consecutive differing sample
   assign flip = (clk_sync != filt_reg) && (filt_cnt_reg == FCW'(FILTER_LEN - 1));
   assign fall = flip && filt_reg;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         filt_cnt_reg <= '0;
         filt_reg     <= 1'b1;
      end else if (clk_sync == filt_reg) begin
         filt_cnt_reg <= '0;
      end else if (flip) begin
         filt_cnt_reg <= '0;
         filt_reg     <= clk_sync;
      end else begin
         filt_cnt_reg <= filt_cnt_reg + FCW'(1);
      end
   end

   frame_state_t state_reg, state_next;
   logic [2:0]   bit_cnt_reg, bit_cnt_next;
   logic [7:0]   shift_reg, shift_next;
   logic         par_reg, par_next;
   logic [TW-1:0] tout_reg, tout_next;
   logic [7:0]   rx_byte_reg, rx_byte_next;
   logic         rx_strobe_reg, rx_strobe_next;
   logic         frame_err_reg, frame_err_next;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         shift_reg     <= '0;
         par_reg       <= 1'b0;
         tout_reg      <= '0;
         rx_byte_reg   <= '0;
         rx_strobe_reg <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         shift_reg     <= shift_next;
         par_reg       <= par_next;
         tout_reg      <= tout_next;
         rx_byte_reg   <= rx_byte_next;
         rx_strobe_reg <= rx_strobe_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      shift_next     = shift_reg;
      par_next       = par_reg;
      rx_byte_next   = rx_byte_reg;
      rx_strobe_next = 1'b0;
      frame_err_next = 1'b0;
      tout_next      = (state_reg == IDLE || fall) ? '0 : tout_reg + TW'(1);

      case (state_reg)
         IDLE: begin
            if (fall && !data_sync) begin
               state_next   = DATA;
               bit_cnt_next = '0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_next   = {data_sync, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) state_next = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_next   = data_sync;
               state_next = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_next = IDLE;
               if (data_sync && (^{shift_reg, par_reg})) begin
                  rx_byte_next   = shift_reg;
                  rx_strobe_next = 1'b1;
               end else begin
                  frame_err_next = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      // A stalled frame is abandoned; partial data is overwritten by the next frame
      if (state_reg != IDLE && !fall && tout_reg == TW'(TIMEOUT_CYC - 1)) begin
         state_next     = IDLE;
         frame_err_next = 1'b1;
      end
   end

   logic [7:0] hid;
   ps2_to_hid u_map (
      .scan (rx_byte_reg),
      .hid  (hid)
   );

   dec_state_t dec_reg, dec_next;
   logic [7:0] keycode_reg, keycode_next;
   logic       ext_reg, ext_next;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         dec_reg     <= NORM;
         keycode_reg <= HID_NONE;
         ext_reg     <= 1'b0;
      end else begin
         dec_reg     <= dec_next;
         keycode_reg <= keycode_next;
         ext_reg     <= ext_next;
      end
   end

   always_comb begin
      dec_next     = dec_reg;
      keycode_next = keycode_reg;
      ext_next     = ext_reg;
      if (rx_strobe_reg) begin
         case (dec_reg)
            NORM, GOT_E0: begin
               if (rx_byte_reg == SC_PREFIX_E0) begin
                  dec_next = GOT_E0;
               end else if (rx_byte_reg == SC_BREAK_F0) begin
                  dec_next = (dec_reg == GOT_E0) ? GOT_E0F0 : GOT_F0;
               end else begin
                  dec_next = NORM;
                  if (hid != HID_NONE) begin
                     keycode_next = hid;
                     ext_next     = (dec_reg == GOT_E0);
                  end
               end
            end
            default: begin
               // Only the release of the held key (same prefix) clears it
               dec_next = NORM;
               if (hid == keycode_reg && ext_reg == (dec_reg == GOT_E0F0)) begin
                  keycode_next = HID_NONE;
                  ext_next     = 1'b0;
               end
            end
         endcase
      end
   end

   assign bus.keycode   = keycode_reg;
   assign bus.rx_byte   = rx_byte_reg;
   assign bus.rx_strobe = rx_strobe_reg;
   assign bus.ext       = ext_reg;
   assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_keycode_rx;
   localparam int HALF = 20;

   logic Clk = 1'b0;
   logic Reset = 1'b1;

   ps2_keycode_rx_if bus_if ();

   ps2_keycode_rx #(
      .FILTER_LEN  (8),
      .TIMEOUT_CYC (50000)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus_if.slave)
   );

   always #10 Clk = ~Clk;

   int n_checks = 0;
   int n_fail   = 0;

   int         strobe_cnt = 0;
   int         err_cnt    = 0;
   int         kc_chg_cnt = 0;
   logic       strobe_pend = 1'b0;
   logic [7:0] kc_at_strobe    = 8'h00;
   logic [7:0] kc_after_strobe = 8'h00;
   logic [7:0] kc_prev         = 8'h00;

   always @(negedge Clk) begin
      if (bus_if.rx_strobe === 1'b1) begin
         strobe_cnt++;
         kc_at_strobe = bus_if.keycode;
         strobe_pend  = 1'b1;
      end else if (strobe_pend) begin
         kc_after_strobe = bus_if.keycode;
         strobe_pend     = 1'b0;
      end
      if (bus_if.frame_err === 1'b1) err_cnt++;
      if (bus_if.keycode !== kc_prev) kc_chg_cnt++;
      kc_prev = bus_if.keycode;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic send_bit(input logic b);
      bus_if.ps2_data = b;
      wait_cyc(HALF);
      bus_if.ps2_clk = 1'b0;
      wait_cyc(HALF);
      bus_if.ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic bad_stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(data[i]);
      send_bit((~^data) ^ bad_par);
      send_bit(~bad_stop);
      bus_if.ps2_data = 1'b1;
      wait_cyc(2 * HALF);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_keycode"},   32'(bus_if.keycode),   32'h00);
      check_val({tag, "_rx_byte"},   32'(bus_if.rx_byte),   32'h00);
      check_val({tag, "_rx_strobe"}, 32'(bus_if.rx_strobe), 32'h0);
      check_val({tag, "_ext"},       32'(bus_if.ext),       32'h0);
      check_val({tag, "_frame_err"}, 32'(bus_if.frame_err), 32'h0);
   endtask

   int s0, e0, c0;

   initial begin
      bus_if.ps2_clk  = 1'b1;
      bus_if.ps2_data = 1'b1;
      wait_cyc(5);
      check_reset_outputs("rst");
      Reset = 1'b0;
      wait_cyc(50);

      // Make of A
      s0 = strobe_cnt;
      send_frame(8'h1C, 1'b0, 1'b0);
      check_val("make_a_strobes", 32'(strobe_cnt - s0), 32'd1);
      check_val("make_a_rx_byte", 32'(bus_if.rx_byte), 32'h1C);
      check_val("make_a_kc_at_strobe", 32'(kc_at_strobe), 32'h00);
      check_val("make_a_kc_next_cyc", 32'(kc_after_strobe), 32'h04);
      check_val("make_a_ext", 32'(bus_if.ext), 32'h0);

      // D with bad parity is dropped
      e0 = err_cnt;
      send_frame(8'h23, 1'b1, 1'b0);
      check_val("par_err_pulses", 32'(err_cnt - e0), 32'd1);
      check_val("par_err_strobes", 32'(strobe_cnt - s0), 32'd1);
      check_val("par_err_keycode", 32'(bus_if.keycode), 32'h04);
      check_val("par_err_rx_byte", 32'(bus_if.rx_byte), 32'h1C);

      // Release of A
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check_val("break_a_keycode", 32'(bus_if.keycode), 32'h00);
      check_val("break_a_strobes", 32'(strobe_cnt - s0), 32'd3);

      // Enter with a bad stop bit is dropped
      e0 = err_cnt;
      send_frame(8'h5A, 1'b0, 1'b1);
      check_val("stop_err_pulses", 32'(err_cnt - e0), 32'd1);
      check_val("stop_err_keycode", 32'(bus_if.keycode), 32'h00);

      // Stalled partial frame times out, then W is received cleanly
      e0 = err_cnt;
      s0 = strobe_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      bus_if.ps2_data = 1'b1;
      wait_cyc(60000);
      check_val("timeout_pulses", 32'(err_cnt - e0), 32'd1);
      check_val("timeout_strobes", 32'(strobe_cnt - s0), 32'd0);
      send_frame(8'h1D, 1'b0, 1'b0);
      check_val("after_timeout_keycode", 32'(bus_if.keycode), 32'h1A);
      check_val("after_timeout_errs", 32'(err_cnt - e0), 32'd1);

      // Extended A replaces W
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check_val("ext_make_keycode", 32'(bus_if.keycode), 32'h04);
      check_val("ext_make_ext", 32'(bus_if.ext), 32'h1);

      // Break without prefix does not release the extended key
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check_val("wrong_prefix_keycode", 32'(bus_if.keycode), 32'h04);
      check_val("wrong_prefix_ext", 32'(bus_if.ext), 32'h1);

      // Typematic repeat and an unmapped make leave keycode steady
      c0 = kc_chg_cnt;
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      send_frame(8'h15, 1'b0, 1'b0);
      check_val("repeat_kc_changes", 32'(kc_chg_cnt - c0), 32'd0);
      check_val("repeat_keycode", 32'(bus_if.keycode), 32'h04);
      check_val("unmapped_rx_byte", 32'(bus_if.rx_byte), 32'h15);

      // Correct extended break
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b0, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check_val("ext_break_keycode", 32'(bus_if.keycode), 32'h00);
      check_val("ext_break_ext", 32'(bus_if.ext), 32'h0);

      // 3-cycle low glitch with data low must not look like a start bit
      e0 = err_cnt;
      bus_if.ps2_data = 1'b0;
      wait_cyc(2);
      bus_if.ps2_clk = 1'b0;
      wait_cyc(3);
      bus_if.ps2_clk = 1'b1;
      wait_cyc(2);
      bus_if.ps2_data = 1'b1;
      wait_cyc(100);
      send_frame(8'h29, 1'b0, 1'b0);
      check_val("glitch_rx_byte", 32'(bus_if.rx_byte), 32'h29);
      check_val("glitch_keycode", 32'(bus_if.keycode), 32'h2C);
      check_val("glitch_errs", 32'(err_cnt - e0), 32'd0);

      // Reset mid-frame, then resume on the next start bit
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      #3 Reset = 1'b1;
      #1 check_reset_outputs("mid_rst");
      bus_if.ps2_clk  = 1'b1;
      bus_if.ps2_data = 1'b1;
      wait_cyc(10);
      check_reset_outputs("held_rst");
      Reset = 1'b0;
      wait_cyc(50);
      s0 = strobe_cnt;
      send_frame(8'h5A, 1'b0, 1'b0);
      check_val("post_rst_rx_byte", 32'(bus_if.rx_byte), 32'h5A);
      check_val("post_rst_keycode", 32'(bus_if.keycode), 32'h28);
      check_val("post_rst_strobes", 32'(strobe_cnt - s0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive equal synchronized samples required before the filtered ps2_clk changes level.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50000 (1 ms at 50 MHz): maximum Clk cycles between ps2_clk falling edges inside one frame.
REQ-003 Clk  input  1  system clock, 50 MHz; one clock, all logic rising-edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous.
REQ-006 ps2_data  input  1  raw PS/2 data from the keyboard, asynchronous.
REQ-007 keycode  output  8  USB-HID code of the currently held key, 0x00 when no key is held; drives the game's keycode input in place of the SoC path.
REQ-008 rx_byte  output  8  last correctly received raw scan byte.
REQ-009 rx_strobe  output  1  one-cycle pulse when rx_byte updates.
REQ-010 ext  output  1  1 when the held key was preceded by prefix 0xE0.
REQ-011 frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-012 Both inputs SHALL pass a 2-flop synchronizer; ps2_clk SHALL then pass the FILTER_LEN glitch filter; a falling edge of the filtered clock SHALL produce one internal fall pulse.
REQ-013 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE -> DATA on fall with ps2_data = 0; fall with ps2_data = 1 in IDLE SHALL be ignored.
REQ-015 DATA SHALL shift 8 bits LSB first, one per fall, then go to PARITY.
REQ-016 PARITY SHALL capture one bit, then go to STOP; odd parity over the 8 data bits plus parity bit is required.
REQ-017 On the STOP fall: if stop = 1 and parity good, rx_byte updates and rx_strobe pulses on the next Clk cycle; otherwise frame_err pulses and the byte is discarded; FSM returns to IDLE in both cases.
REQ-018 A non-IDLE state with no fall for TIMEOUT_CYC cycles SHALL return to IDLE, pulse frame_err once and discard partial data; the timeout counter SHALL clear on every fall and while in IDLE.
REQ-019 Decoder states: NORM, GOT_E0, GOT_F0, GOT_E0F0, advanced only on rx_strobe.
REQ-020 In NORM or GOT_E0: byte 0xE0 -> GOT_E0; byte 0xF0 -> GOT_F0, or GOT_E0F0 from GOT_E0; any other byte is a make code: keycode <= map(byte), ext <= (state = GOT_E0), next NORM.
REQ-021 In GOT_F0 or GOT_E0F0: the break byte clears keycode to 0x00 and ext to 0 only if map(byte) equals keycode and the prefix matches ext; otherwise keycode is unchanged; next NORM.
REQ-022 A repeated make of the held key SHALL leave keycode unchanged, with no glitch.
REQ-023 map (set 2 -> HID): 0x1C->0x04 (A), 0x23->0x07 (D), 0x1D->0x1A (W), 0x1B->0x16 (S), 0x29->0x2C (space), 0x5A->0x28 (enter), 0x76->0x29 (esc); all others -> 0x00.
REQ-024 A make code mapping to 0x00 SHALL leave keycode unchanged.
REQ-025 keycode and ext SHALL update on the Clk cycle after rx_strobe.
REQ-026 A frame_err SHALL not change the decoder state.

Reset
REQ-027 Reset SHALL force, asynchronously: keycode = 0x00, rx_byte = 0x00, rx_strobe = 0, ext = 0, frame_err = 0, frame FSM = IDLE, decoder = NORM, filter output = 1, timeout counter = 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release, reception SHALL resume on the next start bit.

Structure
REQ-029 A shared package SHALL hold the frame and decoder state enums, the constants 0xE0 and 0xF0, and the HID code constants.
REQ-030 The scan-code map SHALL be a combinational sub-module ps2_to_hid (8-bit in, 8-bit out).

Verification
REQ-031 Send 0x1C with odd parity -> rx_strobe pulses once, rx_byte = 0x1C, keycode = 0x04 one cycle later.
REQ-032 Send 0x1C, then 0xF0, then 0x1C -> keycode goes 0x04 -> 0x00; rx_strobe pulses 3 times.
REQ-033 Send 0x23 with a parity error -> frame_err pulses once, no rx_strobe, keycode unchanged.
REQ-034 Send start bit plus 4 data bits, then stall 60000 cycles -> one frame_err pulse; a following 0x1D frame gives keycode = 0x1A.
REQ-035 Send 0xE0, 0x1C -> keycode = 0x04, ext = 1; then 0xF0, 0x1C without the 0xE0 prefix -> keycode stays 0x04.
REQ-036 Inject a 3-cycle low glitch on ps2_clk in IDLE -> no fall pulse and no state change; assert Reset mid-frame -> all outputs at reset values.
